// File: rtl/exp_mask_multi_ctrl_pkg.sv
// Shared ML-DSA constants and ExpandMask sampler types.
// mldsa_params_pkg must come before mldsa_sampler_pkg in the compile order.
package mldsa_params_pkg;
  localparam int MLDSA_Q       = 32'd8380417;
  localparam int MLDSA_Q_WIDTH = 32'd23;
endpackage

package mldsa_sampler_pkg;
  localparam int EXPM_NUM_SAMPLERS = 32'd4;
  localparam int EXPM_SAMPLE_W     = 32'd20;
  localparam int EXPM_NUM_COEFF    = 32'd256;
  localparam int EXPM_GAMMA1_17    = 32'd131072;
  localparam int EXPM_GAMMA1_19    = 32'd524288;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } expm_state_e;

  // 0: gamma1 = 2^17, 1: gamma1 = 2^19
  typedef logic expm_mode_t;
endpackage

// File: rtl/exp_mask_multi_ctrl_if.sv
// Sample-in / coefficient-out handshake bundle for exp_mask_multi_ctrl.
// The slave modport is the converter; the master modport is upstream plus downstream.
interface exp_mask_multi_ctrl_if
  import mldsa_sampler_pkg::*;
  import mldsa_params_pkg::*;
#(
  parameter int NUM_SAMPLERS = EXPM_NUM_SAMPLERS,
  parameter int SAMPLE_W     = EXPM_SAMPLE_W,
  parameter int COEFF_W      = MLDSA_Q_WIDTH
) ();
  logic                             data_valid_i;
  logic                             data_hold_o;
  logic [NUM_SAMPLERS*SAMPLE_W-1:0] data_i;
  logic                             data_valid_o;
  logic                             hold_i;
  logic [NUM_SAMPLERS*COEFF_W-1:0]  data_o;

  modport master (
    output data_valid_i, data_i, hold_i,
    input  data_hold_o, data_valid_o, data_o
  );

  modport slave (
    input  data_valid_i, data_i, hold_i,
    output data_hold_o, data_valid_o, data_o
  );
endinterface

// File: rtl/exp_mask_multi_ctrl_lane.sv
// Single-lane ExpandMask mapping r -> (gamma1 - r) mod q.
// The arithmetic uses one guard bit so that q + gamma1 - r cannot wrap.
module exp_mask_lane
  import mldsa_sampler_pkg::*;
#(
  parameter int SAMPLE_W = 20,
  parameter int COEFF_W  = 23,
  parameter int Q        = 8380417
) (
  input  logic [SAMPLE_W-1:0] lane_i,
  input  expm_mode_t          mode_i,
  output logic [COEFF_W-1:0]  coeff_o
);
  localparam int CALC_W = COEFF_W + 1;

  logic [CALC_W-1:0] r_s;
  logic [CALC_W-1:0] g_s;
  logic [CALC_W-1:0] diff_s;

  // In the 2^17 mode only the low 18 sample bits are meaningful.
  assign r_s = mode_i ? CALC_W'(lane_i) : CALC_W'(lane_i[17:0]);
  assign g_s = mode_i ? CALC_W'(EXPM_GAMMA1_19) : CALC_W'(EXPM_GAMMA1_17);

  // Lift negative differences back into [0, q-1].
  always_comb begin
    diff_s = '0;
    if (r_s <= g_s) begin
      diff_s = g_s - r_s;
    end else begin
      diff_s = CALC_W'(Q) + g_s - r_s;
    end
  end

  assign coeff_o = COEFF_W'(diff_s);
endmodule

// File: rtl/exp_mask_multi_ctrl.sv
// Multi-lane ExpandMask converter: FSM, beat counter and output register
// around NUM_SAMPLERS combinational exp_mask_lane instances.
module exp_mask_multi_ctrl
  import mldsa_params_pkg::*;
  import mldsa_sampler_pkg::*;
#(
  parameter int NUM_SAMPLERS = EXPM_NUM_SAMPLERS,
  parameter int SAMPLE_W     = EXPM_SAMPLE_W,
  parameter int COEFF_W      = MLDSA_Q_WIDTH,
  parameter int NUM_COEFF    = EXPM_NUM_COEFF,
  parameter int Q            = MLDSA_Q
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  zeroize,
  input  logic                  start_i,
  input  logic                  mode_i,
  exp_mask_multi_ctrl_if.slave  bus_if,
  output logic                  done_o,
  output logic                  busy_o
);
  localparam int NUM_BEATS = NUM_COEFF / NUM_SAMPLERS;
  localparam int CNT_W     = $clog2(NUM_BEATS) + 1;
  localparam int DATA_W    = NUM_SAMPLERS * COEFF_W;

  expm_state_e       state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  expm_mode_t        mode_q, mode_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  logic [DATA_W-1:0] coeff_s;
  logic              cnt_full_s;
  logic              out_stall_s;
  logic              hold_s;
  logic              accept_s;

  for (genvar i = 0; i < NUM_SAMPLERS; i++) begin : g_lane
    exp_mask_lane #(
      .SAMPLE_W (SAMPLE_W),
      .COEFF_W  (COEFF_W),
      .Q        (Q)
    ) u_lane (
      .lane_i  (bus_if.data_i[i*SAMPLE_W +: SAMPLE_W]),
      .mode_i  (mode_q),
      .coeff_o (coeff_s[i*COEFF_W +: COEFF_W])
    );
  end

  // A full counter also holds upstream so a surplus beat is never taken.
  assign cnt_full_s  = (beat_cnt_q == CNT_W'(NUM_BEATS));
  assign out_stall_s = valid_q & bus_if.hold_i;
  assign hold_s      = (state_q != RUN) | out_stall_s | cnt_full_s;
  assign accept_s    = bus_if.data_valid_i & ~hold_s;

  // Next-state, counter and output-register update; zeroize wins over everything.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    mode_d     = mode_q;
    data_d     = data_q;
    valid_d    = valid_q;
    if (zeroize) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
      mode_d     = 1'b0;
      data_d     = '0;
      valid_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d    = RUN;
            beat_cnt_d = '0;
            mode_d     = mode_i;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (cnt_full_s) begin
            state_d = DRAIN;
          end else if (accept_s) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end else begin
            state_d = RUN;
          end
        end
        DRAIN: begin
          if (!valid_q || !bus_if.hold_i) begin
            state_d = DONE;
          end else begin
            state_d = DRAIN;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase

      if (accept_s) begin
        data_d  = coeff_s;
        valid_d = 1'b1;
      end else if (!bus_if.hold_i) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      mode_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      mode_q     <= mode_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  assign bus_if.data_hold_o  = hold_s;
  assign bus_if.data_valid_o = valid_q;
  assign bus_if.data_o       = data_q;
  assign done_o              = (state_q == DONE);
  assign busy_o              = (state_q != IDLE);
endmodule

// File: tb/tb_exp_mask_multi_ctrl.sv
// Scoreboard bench for exp_mask_multi_ctrl: accepted beats push model results,
// an independent monitor pops and compares whatever the DUT presents.
module tb_exp_mask_multi_ctrl;
  localparam int      NS = 4;
  localparam int      SW = 20;
  localparam int      CW = 23;
  localparam int      NC = 256;
  localparam int      NB = NC / NS;
  localparam longint  QM = 64'd8380417;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic zeroize = 1'b0;
  logic start_i = 1'b0;
  logic mode_i  = 1'b0;
  logic done_o;
  logic busy_o;

  exp_mask_multi_ctrl_if #(.NUM_SAMPLERS(NS), .SAMPLE_W(SW), .COEFF_W(CW)) bus_if ();

  exp_mask_multi_ctrl #(
    .NUM_SAMPLERS (NS),
    .SAMPLE_W     (SW),
    .COEFF_W      (CW),
    .NUM_COEFF    (NC),
    .Q            (32'd8380417)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .zeroize (zeroize),
    .start_i (start_i),
    .mode_i  (mode_i),
    .bus_if  (bus_if),
    .done_o  (done_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [NS*CW-1:0] exp_q[$];
  int   cyc = 0;
  int   acc_cnt = 0;
  int   out_cnt = 0;
  int   first_out_cyc = 0;
  int   last_out_cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   done_base = 0;
  logic cur_mode = 1'b0;

  // (gamma1 - r) mod q straight from the definition
  function automatic logic [CW-1:0] model_coeff(input logic [SW-1:0] lane, input logic m);
    longint g, r, v;
    g = m ? 64'sd524288 : 64'sd131072;
    r = m ? longint'(lane) : longint'(lane & 20'h3FFFF);
    v = (g - r) % QM;
    if (v < 0) v = v + QM;
    return CW'(v);
  endfunction

  function automatic logic [NS*CW-1:0] model_beat(input logic [NS*SW-1:0] d, input logic m);
    logic [NS*CW-1:0] res;
    res = '0;
    for (int i = 0; i < NS; i++) res[i*CW +: CW] = model_coeff(d[i*SW +: SW], m);
    return res;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Stimulus-side scoreboard feed: every beat the DUT will take at the next edge.
  initial forever begin
    @(negedge clk);
    if (!rst && !zeroize && bus_if.data_valid_i && !bus_if.data_hold_o) begin
      exp_q.push_back(model_beat(bus_if.data_i, cur_mode));
      acc_cnt++;
    end
  end

  // Output monitor: compare consumed beats, check frozen beats, count done pulses.
  initial forever begin
    @(negedge clk);
    if (!rst && !zeroize) begin
      if (bus_if.data_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {127'd0, bus_if.data_valid_o}, 128'd0);
        end else if (bus_if.hold_i) begin
          check("frozen_data", bus_if.data_o, exp_q[0]);
          check("stall_hold", bus_if.data_hold_o, 1'b1);
        end else begin
          check("beat_data", bus_if.data_o, exp_q.pop_front());
          out_cnt++;
          if (out_cnt == 1) first_out_cyc = cyc;
          last_out_cyc = cyc;
        end
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  function automatic logic [SW-1:0] rand_lane();
    logic [SW-1:0] v;
    v = SW'($urandom);
    case ($urandom_range(5))
      0:       v = 20'h00000;
      1:       v = 20'h20000;
      2:       v = 20'h80000;
      3:       v = 20'hFFFFF;
      4:       v = 20'h20001;
      default: v = SW'($urandom);
    endcase
    return v;
  endfunction

  function automatic logic [NS*SW-1:0] rand_data();
    logic [NS*SW-1:0] d;
    for (int i = 0; i < NS; i++) d[i*SW +: SW] = rand_lane();
    return d;
  endfunction

  task automatic start_poly(input logic m);
    @(posedge clk); #1;
    start_i = 1'b1; mode_i = m; cur_mode = m;
    bus_if.data_valid_i = 1'b0; bus_if.hold_i = 1'b0;
    acc_cnt = 0; out_cnt = 0; done_base = done_cnt;
    @(posedge clk); #1;
    start_i = 1'b0; mode_i = ~m;
  endtask

  task automatic directed(input string nm, input logic [NS*SW-1:0] lanes, input logic [NS*CW-1:0] expv);
    bit taken = 1'b0;
    bus_if.data_valid_i = 1'b1; bus_if.data_i = lanes; bus_if.hold_i = 1'b0;
    for (int i = 0; i < 20 && !taken; i++) begin
      @(negedge clk);
      taken = !bus_if.data_hold_o;
    end
    check({nm, "_accepted"}, {127'd0, taken}, 128'd1);
    @(posedge clk); #1;
    bus_if.data_valid_i = 1'b0;
    @(negedge clk);
    check({nm, "_valid"}, bus_if.data_valid_o, 1'b1);
    check({nm, "_data"}, bus_if.data_o, expv);
    @(posedge clk); #1;
  endtask

  // hold_mode: 0 never stall, 1 random stalls, 2 three-cycle stall window
  task automatic run_poly(input int valid_pct, input int hold_mode, input int stop_at);
    for (int i = 0; i < 3000 && acc_cnt < stop_at; i++) begin
      bus_if.data_valid_i = ($urandom_range(99) < valid_pct);
      bus_if.data_i       = rand_data();
      case (hold_mode)
        1:       bus_if.hold_i = ($urandom_range(99) < 30);
        2:       bus_if.hold_i = (i >= 20 && i <= 22);
        default: bus_if.hold_i = 1'b0;
      endcase
      @(posedge clk); #1;
    end
    check("accept_budget", {127'd0, acc_cnt >= stop_at}, 128'd1);
    bus_if.hold_i = 1'b0;
  endtask

  task automatic finish_poly(input bit tight);
    bit seen = 1'b0;
    bus_if.data_valid_i = 1'b1;
    bus_if.data_i       = rand_data();
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      check("overrun_hold", bus_if.data_hold_o, 1'b1);
      seen = done_o;
    end
    check("done_seen", {127'd0, seen}, 128'd1);
    @(posedge clk); #1;
    bus_if.data_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_cnt, done_base + 1);
    check("accept_count", acc_cnt, NB);
    check("out_count", out_cnt, NB);
    check("queue_empty", exp_q.size(), 0);
    check("done_latency", done_cyc, last_out_cyc + 2);
    check("busy_idle", busy_o, 1'b0);
    if (tight) check("back_to_back", last_out_cyc - first_out_cyc, NB - 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.data_valid_i = 1'b0;
    bus_if.data_i       = '0;
    bus_if.hold_i       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", bus_if.data_valid_o, 1'b0);
    check("rst_data", bus_if.data_o, '0);
    check("rst_done", done_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_hold", bus_if.data_hold_o, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    // mode 0 boundary lanes, then random traffic with stalls
    start_poly(1'b0);
    check("busy_run", busy_o, 1'b1);
    directed("mode0", {20'hFFFFF, 20'h20001, 20'h20000, 20'h00000},
             {23'd8249346, 23'd8380416, 23'd0, 23'd131072});
    run_poly(80, 1, NB);
    finish_poly(1'b0);

    // mode 1 boundary lanes
    start_poly(1'b1);
    directed("mode1", {20'hFFFFF, 20'h80000, 20'h7FFFF, 20'h00000},
             {23'd7856130, 23'd0, 23'd1, 23'd524288});
    run_poly(60, 1, NB);
    finish_poly(1'b0);

    // full throughput
    start_poly(1'b1);
    run_poly(100, 0, NB);
    finish_poly(1'b1);

    // three-cycle stall mid-stream
    start_poly(1'b0);
    run_poly(100, 2, NB);
    finish_poly(1'b0);

    // zeroize after beat 10, then a clean mode-1 polynomial
    start_poly(1'b0);
    run_poly(100, 0, 10);
    zeroize = 1'b1;
    bus_if.data_valid_i = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    bus_if.data_valid_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("zero_valid", bus_if.data_valid_o, 1'b0);
    check("zero_busy", busy_o, 1'b0);
    check("zero_hold", bus_if.data_hold_o, 1'b1);
    check("zero_data", bus_if.data_o, '0);
    repeat (6) @(posedge clk);
    #1;
    check("zero_no_done", done_cnt, done_base);
    start_poly(1'b1);
    run_poly(100, 0, NB);
    finish_poly(1'b1);

    // asynchronous reset between edges during RUN
    start_poly(1'b1);
    run_poly(100, 0, 20);
    bus_if.data_valid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", bus_if.data_valid_o, 1'b0);
    check("arst_data", bus_if.data_o, '0);
    check("arst_busy", busy_o, 1'b0);
    check("arst_hold", bus_if.data_hold_o, 1'b1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("arst_no_done", done_cnt, done_base);

    // random polynomials with random mode
    for (int k = 0; k < 3; k++) begin
      start_poly(1'($urandom_range(1)));
      run_poly(70, 1, NB);
      finish_poly(1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
